fifo_write_arbiter: RTL and testbench

- Shares the single write port of one output FIFO between N actor-side requesters.
- Round-robin grant; a granted requester may burst up to BURST words before the grant rotates.
- Writes stop on FIFO almost_full/full backpressure and resume without losing data or grant.
- Sits between actor output ports and a FIFO whose almost_full asserts with at least 1 free slot remaining.

---
 rtl/fifo_write_arbiter_pkg.sv | 18 +
 rtl/fifo_write_arbiter_rr_priority_select.sv | 32 +++
 rtl/fifo_write_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encodings and a
// constant-evaluable ceiling log2 used to size pointers and counters.
package fifo_write_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_select.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// wrapping modulo N, returned one-hot together with an any-valid flag.
module fifo_write_arbiter_rr_priority_select
   import fifo_write_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = clog2(N)
) (
   input  logic [N-1:0]  req_valid,
   input  logic [PW-1:0] rr_ptr,
   output logic [N-1:0]  winner,
   output logic          any_valid
);

   logic [PW-1:0] idx;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment, so no path leaves it holding a value (no latch).
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(rr_ptr) + k) % N);
         if (!any_valid && req_valid[idx]) begin
            winner[idx] = 1'b1;
            any_valid   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port between N requesters: round-robin grants, bursts
// of up to BURST words per grant, stalls on almost_full/full without data loss.
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter int N     = 4,
   parameter int WIDTH = 32,
   parameter int BURST = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       req_valid,
   input  logic [N*WIDTH-1:0] req_data,
   output logic [N-1:0]       req_ack,
   input  logic               almost_full,
   input  logic               full,
   output logic               fifo_write,
   output logic [WIDTH-1:0]   fifo_din,
   output logic [N-1:0]       grant,
   output logic               overflow
);

   localparam int PW = clog2(N);
   localparam int CW = clog2(BURST + 1);

   state_t          state, state_nxt;
   logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
   logic [CW-1:0]   burst_cnt, burst_cnt_nxt;
   logic [N-1:0]    grant_nxt;
   logic [N-1:0]    winner;
   logic            any_valid;
   logic [PW-1:0]   grant_idx;
   logic [PW-1:0]   next_ptr;
   logic [WIDTH-1:0] grant_data;
   logic            g_valid;
   logic            blocked;
   logic            xfer;

   fifo_write_arbiter_rr_priority_select #(.N(N), .PW(PW)) u_select (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .winner    (winner),
      .any_valid (any_valid)
   );

   always_comb begin
      grant_idx  = '0;
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            grant_idx  = PW'(i);
            grant_data = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign g_valid  = req_valid[grant_idx];
   assign blocked  = almost_full | full;
   assign next_ptr = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
   assign req_ack  = (xfer && !reset) ? grant : '0;

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      rr_ptr_nxt    = rr_ptr;
      burst_cnt_nxt = burst_cnt;
      xfer          = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_valid) begin
               grant_nxt     = winner;
               burst_cnt_nxt = '0;
               state_nxt     = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // A dropped valid releases the grant even under backpressure.
            if (!g_valid) begin
               grant_nxt  = '0;
               rr_ptr_nxt = next_ptr;
               state_nxt  = ST_IDLE;
            end else if (blocked) begin
               state_nxt = ST_STALL;
            end else begin
               xfer          = 1'b1;
               burst_cnt_nxt = burst_cnt + 1'b1;
               if (burst_cnt + 1'b1 == CW'(BURST)) begin
                  grant_nxt  = '0;
                  rr_ptr_nxt = next_ptr;
                  state_nxt  = ST_IDLE;
               end
            end
         end
         ST_STALL: begin
            if (!blocked) state_nxt = ST_GRANT;
         end
         default: begin
            grant_nxt = '0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         rr_ptr     <= '0;
         burst_cnt  <= '0;
         grant      <= '0;
         fifo_write <= 1'b0;
         fifo_din   <= '0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         rr_ptr     <= rr_ptr_nxt;
         burst_cnt  <= burst_cnt_nxt;
         grant      <= grant_nxt;
         fifo_write <= xfer;
         if (xfer) fifo_din <= grant_data;
         overflow   <= overflow | (fifo_write & full);
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Table-driven bench for fifo_write_arbiter (N=4, BURST=4): one vector per
// cycle with hand-computed outputs, plus a short hand-written grant sequence.
module tb_fifo_write_arbiter;

   localparam int N     = 4;
   localparam int WIDTH = 32;
   localparam int BURST = 4;

   logic               clk;
   logic               reset;
   logic [N-1:0]       req_valid;
   logic [N*WIDTH-1:0] req_data;
   logic [N-1:0]       req_ack;
   logic               almost_full;
   logic               full;
   logic               fifo_write;
   logic [WIDTH-1:0]   fifo_din;
   logic [N-1:0]       grant;
   logic               overflow;

   fifo_write_arbiter #(.N(N), .WIDTH(WIDTH), .BURST(BURST)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ack     (req_ack),
      .almost_full (almost_full),
      .full        (full),
      .fifo_write  (fifo_write),
      .fifo_din    (fifo_din),
      .grant       (grant),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Requester i presents word n as 0xA000_0000 | i<<8 | n; n advances on ack.
   int       words [N];
   logic [N-1:0] last_ack;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < N; i++)
         req_data[i*WIDTH +: WIDTH] = 32'hA000_0000 | (32'(i) << 8) | 32'(words[i]);
   end

   typedef struct {
      logic        rst;
      logic [3:0]  v;
      logic        af;
      logic        fl;
      logic [3:0]  ack;
      logic [3:0]  gr;
      logic        wr;
      logic [11:0] din;
      logic        ovf;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic [3:0] v, input logic af, input logic fl,
                      input logic [3:0] ack, input logic [3:0] gr, input logic wr,
                      input logic [11:0] din, input logic ovf);
      vec_t t;
      t.rst = rst; t.v = v; t.af = af; t.fl = fl;
      t.ack = ack; t.gr = gr; t.wr = wr; t.din = din; t.ovf = ovf;
      tbl.push_back(t);
   endtask

   task automatic advance_words();
      for (int i = 0; i < N; i++)
         if (last_ack[i]) words[i]++;
   endtask

   task automatic step(input vec_t t, input int row);
      @(negedge clk);
      advance_words();
      reset       = t.rst;
      req_valid   = t.v;
      almost_full = t.af;
      full        = t.fl;
      #1;
      check($sformatf("row%0d_ack", row),   32'(req_ack),    32'(t.ack));
      check($sformatf("row%0d_grant", row), 32'(grant),      32'(t.gr));
      check($sformatf("row%0d_write", row), 32'(fifo_write), 32'(t.wr));
      if (t.wr) check($sformatf("row%0d_din", row), fifo_din, 32'hA000_0000 | 32'(t.din));
      check($sformatf("row%0d_ovf", row),   32'(overflow),   32'(t.ovf));
      last_ack = req_ack;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      reset = 1'b1; req_valid = '0; almost_full = 1'b0; full = 1'b0;
      last_ack = '0;
      for (int i = 0; i < N; i++) words[i] = 0;

      //   rst v     af fl ack   gr    wr din     ovf
      // Single requester, 6 words: 4-word burst, re-arbitration, 2 more.
      add(1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 12'h000, 0);
      add(0, 4'h1, 0, 0, 4'h0, 4'h0, 0, 12'h000, 0);
      add(0, 4'h1, 0, 0, 4'h1, 4'h1, 0, 12'h000, 0);
      add(0, 4'h1, 0, 0, 4'h1, 4'h1, 1, 12'h000, 0);
      add(0, 4'h1, 0, 0, 4'h1, 4'h1, 1, 12'h001, 0);
      add(0, 4'h1, 0, 0, 4'h1, 4'h1, 1, 12'h002, 0);
      add(0, 4'h1, 0, 0, 4'h0, 4'h0, 1, 12'h003, 0);
      add(0, 4'h1, 0, 0, 4'h1, 4'h1, 0, 12'h000, 0);
      add(0, 4'h1, 0, 0, 4'h1, 4'h1, 1, 12'h004, 0);
      add(0, 4'h0, 0, 0, 4'h0, 4'h1, 1, 12'h005, 0);
      add(0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 12'h000, 0);
      // All requesting after reset: grants rotate 0,1,2,3,0.
      add(1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 12'h000, 0);
      add(0, 4'hF, 0, 0, 4'h0, 4'h0, 0, 12'h000, 0);
      add(0, 4'hF, 0, 0, 4'h1, 4'h1, 0, 12'h000, 0);
      add(0, 4'hF, 0, 0, 4'h1, 4'h1, 1, 12'h006, 0);
      add(0, 4'hF, 0, 0, 4'h1, 4'h1, 1, 12'h007, 0);
      add(0, 4'hF, 0, 0, 4'h1, 4'h1, 1, 12'h008, 0);
      add(0, 4'hF, 0, 0, 4'h0, 4'h0, 1, 12'h009, 0);
      add(0, 4'hF, 0, 0, 4'h2, 4'h2, 0, 12'h000, 0);
      add(0, 4'hF, 0, 0, 4'h2, 4'h2, 1, 12'h100, 0);
      add(0, 4'hF, 0, 0, 4'h2, 4'h2, 1, 12'h101, 0);
      add(0, 4'hF, 0, 0, 4'h2, 4'h2, 1, 12'h102, 0);
      add(0, 4'hF, 0, 0, 4'h0, 4'h0, 1, 12'h103, 0);
      add(0, 4'hF, 0, 0, 4'h4, 4'h4, 0, 12'h000, 0);
      add(0, 4'hF, 0, 0, 4'h4, 4'h4, 1, 12'h200, 0);
      add(0, 4'hF, 0, 0, 4'h4, 4'h4, 1, 12'h201, 0);
      add(0, 4'hF, 0, 0, 4'h4, 4'h4, 1, 12'h202, 0);
      add(0, 4'hF, 0, 0, 4'h0, 4'h0, 1, 12'h203, 0);
      add(0, 4'hF, 0, 0, 4'h8, 4'h8, 0, 12'h000, 0);
      add(0, 4'hF, 0, 0, 4'h8, 4'h8, 1, 12'h300, 0);
      add(0, 4'hF, 0, 0, 4'h8, 4'h8, 1, 12'h301, 0);
      add(0, 4'hF, 0, 0, 4'h8, 4'h8, 1, 12'h302, 0);
      add(0, 4'hF, 0, 0, 4'h0, 4'h0, 1, 12'h303, 0);
      add(0, 4'hF, 0, 0, 4'h1, 4'h1, 0, 12'h000, 0);
      add(0, 4'h0, 0, 0, 4'h0, 4'h1, 1, 12'h00A, 0);
      // Grant 2, almost_full for 3 cycles after its 2nd word, then resume.
      add(0, 4'h4, 0, 0, 4'h0, 4'h0, 0, 12'h000, 0);
      add(0, 4'h4, 0, 0, 4'h4, 4'h4, 0, 12'h000, 0);
      add(0, 4'h4, 0, 0, 4'h4, 4'h4, 1, 12'h204, 0);
      add(0, 4'h4, 1, 0, 4'h0, 4'h4, 1, 12'h205, 0);
      add(0, 4'h4, 1, 0, 4'h0, 4'h4, 0, 12'h000, 0);
      add(0, 4'h4, 1, 0, 4'h0, 4'h4, 0, 12'h000, 0);
      add(0, 4'h4, 0, 0, 4'h0, 4'h4, 0, 12'h000, 0);
      add(0, 4'h4, 0, 0, 4'h4, 4'h4, 0, 12'h000, 0);
      add(0, 4'h4, 0, 0, 4'h4, 4'h4, 1, 12'h206, 0);
      add(0, 4'h0, 0, 0, 4'h0, 4'h0, 1, 12'h207, 0);
      // rr_ptr=3 with 0101: requester 0 wins first (wrap), then 2.
      add(0, 4'h5, 0, 0, 4'h0, 4'h0, 0, 12'h000, 0);
      add(0, 4'h5, 0, 0, 4'h1, 4'h1, 0, 12'h000, 0);
      add(0, 4'h5, 0, 0, 4'h1, 4'h1, 1, 12'h00B, 0);
      add(0, 4'h5, 0, 0, 4'h1, 4'h1, 1, 12'h00C, 0);
      add(0, 4'h5, 0, 0, 4'h1, 4'h1, 1, 12'h00D, 0);
      add(0, 4'h5, 0, 0, 4'h0, 4'h0, 1, 12'h00E, 0);
      add(0, 4'h5, 0, 0, 4'h4, 4'h4, 0, 12'h000, 0);
      add(0, 4'h0, 0, 0, 4'h0, 4'h4, 1, 12'h208, 0);
      add(0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 12'h000, 0);
      // full while fifo_write is high sets sticky overflow.
      add(0, 4'h2, 0, 0, 4'h0, 4'h0, 0, 12'h000, 0);
      add(0, 4'h2, 0, 0, 4'h2, 4'h2, 0, 12'h000, 0);
      add(0, 4'h2, 0, 1, 4'h0, 4'h2, 1, 12'h104, 0);
      add(0, 4'h2, 0, 1, 4'h0, 4'h2, 0, 12'h000, 1);
      add(0, 4'h2, 0, 0, 4'h0, 4'h2, 0, 12'h000, 1);
      add(0, 4'h2, 0, 0, 4'h2, 4'h2, 0, 12'h000, 1);
      add(0, 4'h2, 0, 0, 4'h2, 4'h2, 1, 12'h105, 1);
      add(0, 4'h2, 0, 0, 4'h2, 4'h2, 1, 12'h106, 1);
      // Burst limit reached, almost_full rises right after: IDLE, not STALL.
      add(0, 4'h2, 1, 0, 4'h0, 4'h0, 1, 12'h107, 1);
      add(0, 4'h2, 1, 0, 4'h0, 4'h2, 0, 12'h000, 1);
      add(0, 4'h2, 0, 0, 4'h0, 4'h2, 0, 12'h000, 1);
      add(0, 4'h2, 0, 0, 4'h2, 4'h2, 0, 12'h000, 1);
      // Reset in the 2nd burst cycle drops the in-flight write, rr_ptr back to 0.
      add(1, 4'h2, 0, 0, 4'h0, 4'h2, 1, 12'h108, 1);
      add(0, 4'hA, 0, 0, 4'h0, 4'h0, 0, 12'h000, 0);
      add(0, 4'hA, 0, 0, 4'h2, 4'h2, 0, 12'h000, 0);
      add(0, 4'h0, 0, 0, 4'h0, 4'h2, 1, 12'h109, 0);
      add(0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 12'h000, 0);

      repeat (2) @(negedge clk);
      for (int r = 0; r < tbl.size(); r++) step(tbl[r], r);

      // Hand-written: rr_ptr=2, requester 3 alone; bounded wait for its grant.
      @(negedge clk);
      advance_words();
      last_ack  = '0;
      req_valid = 4'b1000;
      cyc = 0;
      while (grant != 4'b1000 && cyc < 8) begin
         @(negedge clk);
         cyc++;
      end
      check("hs_grant_latency", 32'(cyc), 32'd1);
      #1;
      check("hs_ack", 32'(req_ack), 32'h8);
      @(negedge clk);
      words[3]++;
      req_valid = 4'b0000;
      #1;
      check("hs_write", 32'(fifo_write), 32'd1);
      check("hs_din", fifo_din, 32'hA000_0304);
      check("hs_ack_drop", 32'(req_ack), 32'h0);
      @(negedge clk);
      #1;
      check("hs_write_off", 32'(fifo_write), 32'd0);
      check("hs_grant_off", 32'(grant), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
